fifo_ram_controller: RTL and testbench
======================================

Name: fifo_ram_controller

Overview:
- Master-side controller for ram_interface: drives write_en, write_address, din and read_address, and consumes dout of the dual-ported RAM.
- Turns that RAM (synchronous write, combinational read) into a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Used as the control half of every FIFO in the dataflow fabric, instantiated beside one RAM instance of matching WIDTH/DEPTH.

Parameters:
- WIDTH, 8, data word width; must equal RAM WIDTH.
- DEPTH, 4, number of entries; must equal RAM DEPTH; any value >= 2, not restricted to powers of two.
- AF_LEVEL, DEPTH-1, count threshold at which almost_full asserts (count >= AF_LEVEL).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- in_data  in  WIDTH  write-side data.
- in_valid  in  1  write-side valid.
- in_ready  out  1  write-side ready.
- out_data  out  WIDTH  read-side data (head entry).
- out_valid  out  1  read-side valid.
- out_ready  in  1  read-side ready.
- count  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  count >= AF_LEVEL.
- ram_write_en  out  1  to RAM write_en.
- ram_write_address  out  $clog2(DEPTH)  to RAM write_address.
- ram_din  out  WIDTH  to RAM din.
- ram_read_address  out  $clog2(DEPTH)  to RAM read_address.
- ram_dout  in  WIDTH  from RAM dout (combinational read).

Behaviour:
- Reset: one clock, synchronous, active-low; reset is sampled at the rising edge.
- Reset values, held while rst_n is low: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, almost_full=0, in_ready=0.
- in_ready rises to 1 in the first cycle after rst_n is sampled high.
- Registered state: wr_ptr, rd_ptr, count, full_q, empty_q, ready_en_q (set by first non-reset edge).
- Output assignments:
  - in_ready = ready_en_q & ~full_q.
  - out_valid = ~empty_q.
  - out_data = ram_dout.
- Transfer definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- RAM drive (combinational):
  - ram_write_en = push.
  - ram_write_address = wr_ptr.
  - ram_din = in_data.
  - ram_read_address = rd_ptr.
  - The RAM is never written when push=0.
- Pointer advance: on push wr_ptr advances; on pop rd_ptr advances. Each pointer wraps from DEPTH-1 to 0 by explicit compare, not bit overflow.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flag timing: full_q = (next count == DEPTH) and empty_q = (next count == 0), registered together with count. No combinational path from in_valid or out_ready to either ready/valid output.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 from cycle N+1. No write-to-read bypass into an empty FIFO.
- Full: in_ready=0; in_valid is ignored, with no write and no pointer change. Push and pop are never simultaneous when full, so one freed slot re-opens in_ready the cycle after the pop.
- Empty: out_valid=0; out_data is don't-care, and out_ready is ignored.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance, count holds, and FIFO order is preserved.
- flush=1: at the edge, wr_ptr=rd_ptr=count=0, out_valid=0 next cycle, in_ready=1 next cycle.
  - A push presented in the flush cycle still writes the RAM but is discarded by the pointer reset.
  - rst_n low overrides flush.
- Reset mid-operation: all contents are lost. RAM contents are not cleared; the pointers alone define validity.
- almost_full is registered from the next-count value, using the same timing as full_q.

Test Plan:
1. Reset then fill (DEPTH=4, WIDTH=8): rst_n low 2 cycles, then push 0x11,0x22,0x33,0x44 back-to-back, out_ready=0.
   - in_ready=0 during reset, 1 the cycle after.
   - count 1,2,3,4.
   - almost_full=1 from count=3.
   - in_ready=0 after the 4th push.
   - out_data=0x11, out_valid=1 from the cycle after the first push.
2. Drain: from full, out_ready=1 for 4 cycles.
   - out_data sequence 0x11,0x22,0x33,0x44.
   - in_ready=1 the cycle after the first pop.
   - out_valid=0 and count=0 after the 4th pop.
3. Wrap-around streaming: in_valid=out_ready=1 continuously with data 0x00..0x0F.
   - Output sequence is 0x00..0x0F in order.
   - count settles at 1.
   - ram_write_address cycles 0,1,2,3,0...
   - No word lost or duplicated.
4. Full blocking: push 4 words, hold in_valid=1 with in_data=0x99 for 3 more cycles, then pop all.
   - ram_write_en=0 while full.
   - 0x99 never appears at the output.
5. Flush: push 0xA1,0xA2, then assert flush together with push 0xA3.
   - Next cycle count=0, out_valid=0, in_ready=1.
   - A subsequent push 0xB0 is output first.
6. Empty pop and non-power-of-two depth: with DEPTH=3, assert out_ready with the FIFO empty.
   - No pointer change.
   - Then push 5 and pop 5 interleaved: addresses wrap 0,1,2,0,1 and data order is preserved.

Source files
------------

// File: rtl/fifo_ram_controller.sv
// ============================================================================
// fifo_ram_controller
//   Adds FWFT FIFO control (valid/ready on both sides) to a dual-port RAM
//   that has a synchronous write port and a combinational read port.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_ram_controller #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       ram_write_en,
  output logic [$clog2(DEPTH)-1:0]   ram_write_address,
  output logic [WIDTH-1:0]           ram_din,
  output logic [$clog2(DEPTH)-1:0]   ram_read_address,
  input  logic [WIDTH-1:0]           ram_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q, ready_en_q;
  logic          push, pop;

  assign in_ready    = ready_en_q & ~full_q;
  assign out_valid   = ~empty_q;
  assign out_data    = ram_dout;
  assign count       = count_q;
  assign almost_full = af_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign ram_write_en      = push;
  assign ram_write_address = wr_ptr_q;
  assign ram_din           = in_data;
  assign ram_read_address  = rd_ptr_q;

  // Pointers wrap by compare so that non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      af_q       <= (count_d >= CNT_AF);
      ready_en_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_ram_controller.sv
// ============================================================================
// tb_fifo_ram_controller
//   Directed vector table plus streaming and DEPTH=3 sequences.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance and its RAM
  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, almost_full, we;
  logic [7:0] out_data, din, dout;
  logic [2:0] count;
  logic [1:0] wa, ra;
  logic [7:0] mem4 [4];

  fifo_ram_controller #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full),
    .ram_write_en(we), .ram_write_address(wa), .ram_din(din),
    .ram_read_address(ra), .ram_dout(dout)
  );
  always @(posedge clk) if (we) mem4[wa] <= din;
  assign dout = mem4[ra];

  // DEPTH=3 instance and its RAM
  logic       rst3_n, flush3, iv3, ordy3;
  logic [7:0] id3;
  logic       ir3, ov3, af3, we3;
  logic [7:0] od3, din3, dout3;
  logic [1:0] cnt3, wa3, ra3;
  logic [7:0] mem3 [3];

  fifo_ram_controller #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .flush(flush3),
    .in_data(id3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(ordy3),
    .count(cnt3), .almost_full(af3),
    .ram_write_en(we3), .ram_write_address(wa3), .ram_din(din3),
    .ram_read_address(ra3), .ram_dout(dout3)
  );
  always @(posedge clk) if (we3) mem3[wa3] <= din3;
  assign dout3 = mem3[ra3];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       rst_n, flush, iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir, ov;
    logic [7:0] od;
    logic [2:0] cnt;
    logic       af, we;
    logic [1:0] wa;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int r, input int f, input int iv, input int id,
                              input int o, input int ir, input int ov, input int od,
                              input int c, input int af, input int w, input int a);
    vec_t v;
    v.rst_n = 1'(r); v.flush = 1'(f); v.iv = 1'(iv); v.id = 8'(id); v.ordy = 1'(o);
    v.ir = 1'(ir); v.ov = 1'(ov); v.od = 8'(od); v.cnt = 3'(c);
    v.af = 1'(af); v.we = 1'(w); v.wa = 2'(a);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [7:0] id, input logic o);
    rst_n = r; flush = f; in_valid = iv; in_data = id; out_ready = o;
  endtask

  task automatic drive3(input logic r, input logic iv, input logic [7:0] id, input logic o);
    rst3_n = r; flush3 = 1'b0; iv3 = iv; id3 = id; ordy3 = o;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    drive3(1'b0, 1'b0, 8'h00, 1'b0);

    //  rst fl iv id    or  ir ov od    cnt af we wa
    // Reset, then fill
    add(0, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 0, 0, 0);
    add(0, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 0, 0, 0);
    add(1, 0, 1, 'h11, 0,  0, 0, 'h00, 0, 0, 0, 0);
    add(1, 0, 1, 'h11, 0,  1, 0, 'h00, 0, 0, 1, 0);
    add(1, 0, 1, 'h22, 0,  1, 1, 'h11, 1, 0, 1, 1);
    add(1, 0, 1, 'h33, 0,  1, 1, 'h11, 2, 0, 1, 2);
    add(1, 0, 1, 'h44, 0,  1, 1, 'h11, 3, 1, 1, 3);
    // Drain
    add(1, 0, 0, 'h00, 1,  0, 1, 'h11, 4, 1, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'h22, 3, 1, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'h33, 2, 0, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'h44, 1, 0, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 0, 'h00, 0, 0, 0, 0);
    // Full blocking
    add(1, 0, 1, 'h55, 0,  1, 0, 'h00, 0, 0, 1, 0);
    add(1, 0, 1, 'h66, 0,  1, 1, 'h55, 1, 0, 1, 1);
    add(1, 0, 1, 'h77, 0,  1, 1, 'h55, 2, 0, 1, 2);
    add(1, 0, 1, 'h88, 0,  1, 1, 'h55, 3, 1, 1, 3);
    add(1, 0, 1, 'h99, 0,  0, 1, 'h55, 4, 1, 0, 0);
    add(1, 0, 1, 'h99, 0,  0, 1, 'h55, 4, 1, 0, 0);
    add(1, 0, 1, 'h99, 0,  0, 1, 'h55, 4, 1, 0, 0);
    add(1, 0, 0, 'h00, 1,  0, 1, 'h55, 4, 1, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'h66, 3, 1, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'h77, 2, 0, 0, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'h88, 1, 0, 0, 0);
    add(1, 0, 0, 'h00, 0,  1, 0, 'h00, 0, 0, 0, 0);
    // Flush with a concurrent push
    add(1, 0, 1, 'hA1, 0,  1, 0, 'h00, 0, 0, 1, 0);
    add(1, 0, 1, 'hA2, 0,  1, 1, 'hA1, 1, 0, 1, 1);
    add(1, 1, 1, 'hA3, 0,  1, 1, 'hA1, 2, 0, 1, 2);
    add(1, 0, 1, 'hB0, 0,  1, 0, 'h00, 0, 0, 1, 0);
    add(1, 0, 0, 'h00, 1,  1, 1, 'hB0, 1, 0, 0, 1);
    add(1, 0, 0, 'h00, 0,  1, 0, 'h00, 0, 0, 0, 1);

    next_cycle();
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      @(negedge clk);
      nvec++;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].af));
      chk($sformatf("v%0d write_en", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("v%0d write_addr", i), 32'(wa), 32'(vecs[i].wa));
      next_cycle();
    end

    // Mid-operation reset, then continuous streaming across the wrap
    drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    chk("rst_mid in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid count", 32'(count), 32'd0);
    next_cycle();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b0, (k < 16), 8'(k), 1'b1);
      @(negedge clk);
      nvec++;
      chk($sformatf("s%0d out_valid", k), 32'(out_valid), 32'(k > 0));
      if (k > 0) chk($sformatf("s%0d out_data", k), 32'(out_data), 32'(k - 1));
      chk($sformatf("s%0d count", k), 32'(count), 32'(k > 0));
      chk($sformatf("s%0d write_en", k), 32'(we), 32'(k < 16));
      if (k < 16) chk($sformatf("s%0d write_addr", k), 32'(wa), 32'(k % 4));
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    chk("s_end out_valid", 32'(out_valid), 32'd0);
    chk("s_end count", 32'(count), 32'd0);

    // DEPTH=3: empty pop, interleaved traffic, then fill
    drive3(1'b0, 1'b0, 8'h00, 1'b0);
    next_cycle();
    drive3(1'b1, 1'b0, 8'h00, 1'b0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive3(1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      nvec++;
      chk($sformatf("e%0d out_valid", k), 32'(ov3), 32'd0);
      chk($sformatf("e%0d read_addr", k), 32'(ra3), 32'd0);
      chk($sformatf("e%0d count", k), 32'(cnt3), 32'd0);
      chk($sformatf("e%0d in_ready", k), 32'(ir3), 32'd1);
      next_cycle();
    end
    for (int k = 0; k < 5; k++) begin
      drive3(1'b1, 1'b1, 8'(8'h30 + k), 1'b0);
      @(negedge clk);
      nvec++;
      chk($sformatf("d3p%0d write_en", k), 32'(we3), 32'd1);
      chk($sformatf("d3p%0d write_addr", k), 32'(wa3), 32'(k % 3));
      chk($sformatf("d3p%0d out_valid", k), 32'(ov3), 32'd0);
      next_cycle();
      drive3(1'b1, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      nvec++;
      chk($sformatf("d3q%0d out_valid", k), 32'(ov3), 32'd1);
      chk($sformatf("d3q%0d out_data", k), 32'(od3), 32'(8'h30 + k));
      chk($sformatf("d3q%0d read_addr", k), 32'(ra3), 32'(k % 3));
      chk($sformatf("d3q%0d count", k), 32'(cnt3), 32'd1);
      next_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      drive3(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
      @(negedge clk);
      nvec++;
      chk($sformatf("f%0d count", k), 32'(cnt3), 32'(k));
      chk($sformatf("f%0d in_ready", k), 32'(ir3), 32'(k < 3));
      chk($sformatf("f%0d write_en", k), 32'(we3), 32'(k < 3));
      chk($sformatf("f%0d almost_full", k), 32'(af3), 32'(k >= 2));
      if (k < 3) chk($sformatf("f%0d write_addr", k), 32'(wa3), 32'((k + 2) % 3));
      if (k > 0) chk($sformatf("f%0d out_data", k), 32'(od3), 32'h40);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
